// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random-number block: the maximal-length tap
// table, the reset/fallback seed and the draw FSM state encoding.
package lfsr_pkg;

  // Seed used out of reset and whenever a zero seed is loaded. The all-zero
  // state is a lock-up state for an XOR LFSR and must never be entered.
  localparam logic [31:0] DEFAULT_SEED = 32'd1;

  // Draw sequencer states.
  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_DONE
  } fsm_state_e;

  // Tap masks for a shift-left Fibonacci LFSR: bit k set means state[k]
  // feeds the XOR. Each entry is a primitive polynomial, so every width
  // cycles through all 2^WIDTH-1 non-zero states.
  function automatic logic [31:0] tap_mask(input int unsigned width);
    logic [31:0] mask;
    mask = '0;
    case (width)
      4:  mask = 32'h0000_000C;
      5:  mask = 32'h0000_0014;
      6:  mask = 32'h0000_0030;
      7:  mask = 32'h0000_0060;
      8:  mask = 32'h0000_00B8;
      9:  mask = 32'h0000_0110;
      10: mask = 32'h0000_0240;
      11: mask = 32'h0000_0500;
      12: mask = 32'h0000_0829;
      13: mask = 32'h0000_100D;
      14: mask = 32'h0000_2015;
      15: mask = 32'h0000_6000;
      16: mask = 32'h0000_D008;
      17: mask = 32'h0001_2000;
      18: mask = 32'h0002_0400;
      19: mask = 32'h0004_0023;
      20: mask = 32'h0009_0000;
      21: mask = 32'h0014_0000;
      22: mask = 32'h0030_0000;
      23: mask = 32'h0042_0000;
      24: mask = 32'h00E1_0000;
      25: mask = 32'h0120_0000;
      26: mask = 32'h0200_0023;
      27: mask = 32'h0400_0013;
      28: mask = 32'h0900_0000;
      29: mask = 32'h1400_0000;
      30: mask = 32'h2000_0029;
      31: mask = 32'h4800_0000;
      32: mask = 32'h8020_0003;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_rng_if.sv
// Control/result bundle between a consumer (master) and the LFSR random
// number generator (slave).
interface lfsr_rng_if #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 5
);

  logic             en;
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             req;
  logic [OUT_W-1:0] limit;
  logic             ack;
  logic             ready;
  logic             valid;
  logic [OUT_W-1:0] value;
  logic             fallback;
  logic             err;
  logic [WIDTH-1:0] state;

  modport master (
    output en, seed_load, seed, req, limit, ack,
    input  ready, valid, value, fallback, err, state
  );

  modport slave (
    input  en, seed_load, seed, req, limit, ack,
    output ready, valid, value, fallback, err, state
  );

endinterface

// File: rtl/lfsr_core.sv
// Fibonacci shift-left LFSR with a seed load that can never enter the
// all-zero lock-up state.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(tap_mask(WIDTH))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             fb;

  // Feedback bit and next state: load beats advance, advance beats hold.
  always_comb begin
    fb      = ^(state_q & TAPS);
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == '0) ? WIDTH'(DEFAULT_SEED) : seed_i;
    end else if (en_i) begin
      state_d = {state_q[WIDTH-2:0], fb};
    end
  end

  // Shift register; reset lands on the default seed, not zero.
  // NOTE: non-blocking (<=) in clocked blocks so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WIDTH'(DEFAULT_SEED);
    else     state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/lfsr_rng.sv
// Bounded random draw by rejection sampling on an LFSR: candidates at or
// above the limit are rejected, and after MAX_TRIES rejections the draw
// returns limit-1 with the fallback flag set.
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int OUT_W     = 5,
  parameter int MAX_TRIES = 8
) (
  input  logic        clk,
  input  logic        rst,
  lfsr_rng_if.slave   bus
);

  localparam int               TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [WIDTH-1:0] TAPS  = WIDTH'(tap_mask(WIDTH));

  fsm_state_e       fsm_q;
  logic [OUT_W-1:0] limit_q;
  logic [OUT_W-1:0] value_q;
  logic [TRY_W-1:0] tries_q;
  logic [TRY_W-1:0] tries_d;
  logic             valid_q;
  logic             ready_q;
  logic             fallback_q;
  logic             err_q;
  logic [WIDTH-1:0] lfsr_state;
  logic [OUT_W-1:0] cand;
  logic             advance;

  // The LFSR free-runs on en and is also stepped once per DRAW cycle so each
  // attempt sees a fresh candidate.
  assign advance = bus.en | (fsm_q == S_DRAW);
  assign cand    = lfsr_state[OUT_W-1:0];
  assign tries_d = tries_q + TRY_W'(1);

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .en_i   (advance),
    .load_i (bus.seed_load),
    .seed_i (bus.seed),
    .state_o(lfsr_state)
  );

  // Draw sequencer with registered handshake and result outputs.
  // NOTE: every control flop is reset so an asynchronous reset mid-draw
  // discards the draw outright and no stale valid can follow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= S_IDLE;
      limit_q    <= '0;
      tries_q    <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      fallback_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (bus.req) begin
            limit_q    <= bus.limit;
            tries_q    <= '0;
            value_q    <= '0;
            fallback_q <= 1'b0;
            ready_q    <= 1'b0;
            if (bus.limit == '0) begin
              // An empty range cannot be sampled: report it immediately.
              err_q   <= 1'b1;
              valid_q <= 1'b1;
              fsm_q   <= S_DONE;
            end else begin
              err_q <= 1'b0;
              fsm_q <= S_DRAW;
            end
          end
        end
        S_DRAW: begin
          if (cand < limit_q) begin
            value_q <= cand;
            valid_q <= 1'b1;
            fsm_q   <= S_DONE;
          end else begin
            tries_q <= tries_d;
            if (tries_d == TRY_W'(MAX_TRIES)) begin
              value_q    <= limit_q - OUT_W'(1);
              fallback_q <= 1'b1;
              valid_q    <= 1'b1;
              fsm_q      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.ack) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            fsm_q   <= S_IDLE;
          end
        end
        default: begin
          fsm_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.valid    = valid_q;
  assign bus.value    = value_q;
  assign bus.fallback = fallback_q;
  assign bus.err      = err_q;
  assign bus.state    = lfsr_state;

endmodule
